// File: rtl/gate_response_checker.sv
// Sweeps every input vector into a small combinational DUT, waits a settle interval, then
// compares the DUT response to TRUTH. Optional first-failure capture: FIRST_FAIL_CAPTURE_EN.
module gate_response_checker #(
  parameter int unsigned               N_IN   = 2,
  parameter logic [(1 << N_IN)-1:0]    TRUTH  = 4'b1000,
  parameter int unsigned               SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
`ifdef FIRST_FAIL_CAPTURE_EN
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec,
`endif
  output logic [N_IN:0]   err_count
);

  localparam int unsigned     NumVec    = 1 << N_IN;
  localparam logic [N_IN-1:0] LastVec   = N_IN'(NumVec - 1);
  localparam logic [N_IN-1:0] VecOne    = N_IN'(1);
  localparam logic [N_IN:0]   ErrOne    = (N_IN + 1)'(1);
  localparam logic [3:0]      SettleCnt = 4'(SETTLE);

  typedef enum logic [1:0] {StIdle, StApply, StSample, StDone} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic            mismatch;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic            fail_valid_q, fail_valid_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;
`endif

  assign mismatch = (dut_out != TRUTH[vec_q]);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef FIRST_FAIL_CAPTURE_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StApply;
          vec_d   = '0;
          cnt_d   = SettleCnt;
          err_d   = '0;
`ifdef FIRST_FAIL_CAPTURE_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
`endif
        end
      end
      StApply: begin
        if (cnt_q == 4'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        if (mismatch) begin
          err_d = err_q + ErrOne;
`ifdef FIRST_FAIL_CAPTURE_EN
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
`endif
        end
        // Terminal vector always exits, so vec never wraps inside a sweep.
        if (vec_q == LastVec) begin
          state_d = StDone;
        end else begin
          state_d = StApply;
          vec_d   = vec_q + VecOne;
          cnt_d   = SettleCnt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
`endif
    end
  end

  assign busy      = (state_q == StApply) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign pass      = done && (err_q == '0);
  assign dut_in    = busy ? vec_q : '0;
  assign err_count = err_q;

`ifdef FIRST_FAIL_CAPTURE_EN
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: default build (SETTLE=1) plus a SETTLE=0 instance,
// driving behavioural AND / stuck-at-0 / NAND gates.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start0;
  logic [1:0] mode;  // 0: AND, 1: stuck-at-0, 2: NAND
  logic       dut_out, dut_out0;
  logic [1:0] dut_in, dut_in0;
  logic       busy, done, pass, busy0, done0, pass0;
  logic [2:0] err_count, err_count0;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic       fail_valid, fail_valid0;
  logic [1:0] fail_vec, fail_vec0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc;

  always #5 clk = ~clk;

  assign dut_out  = (mode == 2'd0) ? (dut_in[0] & dut_in[1]) :
                    (mode == 2'd1) ? 1'b0 : ~(dut_in[0] & dut_in[1]);
  assign dut_out0 = dut_in0[0] & dut_in0[1];

  gate_response_checker #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_out   (dut_out),
    .dut_in    (dut_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
`ifdef FIRST_FAIL_CAPTURE_EN
    .fail_valid(fail_valid),
    .fail_vec  (fail_vec),
`endif
    .err_count (err_count)
  );

  gate_response_checker #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
    .dut_out   (dut_out0),
    .dut_in    (dut_in0),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
`ifdef FIRST_FAIL_CAPTURE_EN
    .fail_valid(fail_valid0),
    .fail_vec  (fail_vec0),
`endif
    .err_count (err_count0)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start, then count cycles from APPLY entry until done (bounded).
  task automatic run_sweep(output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) check_eq("sweep_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0; mode = 2'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_err", err_count, 0);
    check_eq("rst_dut_in", dut_in, 0);
    rst = 1'b0;

    // Correct AND DUT: vectors 0..3, three cycles each, done 12 cycles after APPLY entry.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check_eq($sformatf("and_dut_in_%0d", k), dut_in, k / 3);
      check_eq($sformatf("and_busy_%0d", k), busy, 1);
      check_eq($sformatf("and_done_lo_%0d", k), done, 0);
      @(negedge clk);
    end
    check_eq("and_done", done, 1);
    check_eq("and_busy_end", busy, 0);
    check_eq("and_pass", pass, 1);
    check_eq("and_err", err_count, 0);
    check_eq("and_done_dut_in", dut_in, 0);
    @(negedge clk);
    check_eq("and_done_hold", done, 1);

    // Stuck-at-0: only vector 3 mismatches.
    mode = 2'd1;
    run_sweep(cyc);
    check_eq("s0_cycles", cyc, 12);
    check_eq("s0_err", err_count, 1);
    check_eq("s0_pass", pass, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check_eq("s0_fail_valid", fail_valid, 1);
    check_eq("s0_fail_vec", fail_vec, 3);
`endif

    // NAND: every vector mismatches.
    mode = 2'd2;
    run_sweep(cyc);
    check_eq("nand_err", err_count, 4);
    check_eq("nand_pass", pass, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check_eq("nand_fail_valid", fail_valid, 1);
    check_eq("nand_fail_vec", fail_vec, 0);
`endif

    // SETTLE=0 instance: two cycles per vector, done after 8.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("s0set_dut_in_%0d", k), dut_in0, k / 2);
      check_eq($sformatf("s0set_busy_%0d", k), busy0, 1);
      @(negedge clk);
    end
    check_eq("s0set_done", done0, 1);
    check_eq("s0set_pass", pass0, 1);
    check_eq("s0set_err", err_count0, 0);

    // start held high: NAND sweep, then AND sweep; done pulses one cycle, period 13.
    mode = 2'd2;
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("held_first_done", done, 1);
    check_eq("held_first_err", err_count, 4);
    mode = 2'd0;
    @(negedge clk);
    check_eq("held_done_one_cycle", done, 0);
    check_eq("held_err_cleared", err_count, 0);
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("held_period", cyc, 13);
    check_eq("held_second_err", err_count, 0);
    check_eq("held_second_pass", pass, 1);
    start = 1'b0;
    @(negedge clk);

    // Reset during SAMPLE of vec 2 in a failing sweep.
    mode = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("mid_dut_in", dut_in, 2);
    check_eq("mid_err", err_count, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_dut_in", dut_in, 0);
    check_eq("mid_rst_err", err_count, 0);
    check_eq("mid_rst_done", done, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check_eq("mid_rst_fail_valid", fail_valid, 0);
`endif
    mode = 2'd0;
    run_sweep(cyc);
    check_eq("post_rst_cycles", cyc, 12);
    check_eq("post_rst_err", err_count, 0);
    check_eq("post_rst_pass", pass, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
